alu_issue_queue: RTL and testbench
==================================

// Module: alu_issue_queue
// PURPOSE
//  Age-ordered, collapsing issue queue for one ALU pipe, directly downstream of dispatch.
//  Accepts up to two instructions per cycle from the dispatch stage (slot mask in_choose_i).
//  Captures CDB results for operands that are not yet ready (wakeup).
//  Issues the oldest instruction whose two operands are both ready, one per cycle, to the ALU.
// PARAMETERS
//  DEPTH      8   number of entries (>=2)
//  PREG_W     6   physical register index width
//  DATA_W     32  operand data width
//  PAYLOAD_W  64  opaque per-instruction control bits (pc/op/wreg_id...), passed through
// PORTS
//  clk              in   1             clock
//  rst_n            in   1             async active-low reset
//  flush_i          in   1             pipeline flush
//  in_valid_i       in   1             dispatch packet valid
//  in_ready_o       out  1             queue can take a full 2-slot packet
//  in_choose_i      in   2             slot k of the packet targets this queue
//  in_preg_i        in   4*PREG_W      src preg, index slot*2+src
//  in_data_i        in   4*DATA_W      src data, same indexing
//  in_data_valid_i  in   4             src data already valid
//  in_payload_i     in   2*PAYLOAD_W   control payload per slot
//  cdb_valid_i      in   2             CDB port result valid (w_reg)
//  cdb_preg_i       in   2*PREG_W      CDB destination preg
//  cdb_data_i       in   2*DATA_W      CDB result data
//  out_valid_o      out  1             issue valid
//  out_ready_i      in   1             ALU accepts issue
//  out_src0_o       out  DATA_W        operand 0 of issued entry
//  out_src1_o       out  DATA_W        operand 1 of issued entry
//  out_payload_o    out  PAYLOAD_W     payload of issued entry
//  count_o          out  $clog2(DEPTH+1) occupied entries
// BEHAVIOUR
//  - Reset (async, rst_n=0): all entry valid bits 0, count_o=0, out_valid_o=0, in_ready_o=1.
//  - Storage: entries 0..count-1 valid, entry 0 oldest. Each entry holds 2x{preg,data,rdy} + payload.
//  - in_ready_o = (DEPTH - count_o >= 2) & ~flush_i. Depends on registered count only,
//    never on the current-cycle issue.
//  - Enqueue fires when in_valid_i & in_ready_o. Selected slots are appended in order slot0, slot1.
//    in_choose_i=00 with a fire writes nothing.
//  - Wakeup: for every valid entry operand with rdy=0, a match against cdb_preg_i[p] with
//    cdb_valid_i[p] sets rdy and latches data at the edge. Port 0 wins if both ports match.
//  - Enqueue bypass: incoming operands with in_data_valid_i=0 are compared against the CDB in the
//    same cycle. On a match the operand is written as rdy=1 with the CDB data.
//  - Select (combinational from registered state): the lowest index entry with both rdy=1.
//    out_valid_o=1 if such an entry exists and ~flush_i. out_* show that entry.
//    An operand woken in cycle N is issuable in cycle N+1 (no same-cycle wakeup-to-issue).
//  - Dequeue when out_valid_o & out_ready_i: the selected entry is removed at the edge and
//    entries above it shift down by one, preserving age order.
//  - Simultaneous enqueue + dequeue: compaction happens first, then new entries are appended at
//    (count-1), so count_next = count - 1 + popcount(in_choose_i).
//  - out_ready_i=0: out_* stay stable unless an older entry becomes ready (the oldest ready
//    always wins). Consumers must not rely on hold.
//  - flush_i: out_valid_o=0 and in_ready_o=0 in the flush cycle. At the edge all valid bits are
//    cleared and count=0. Flush beats enqueue, dequeue and wakeup in the same cycle.
//  - count_o never exceeds DEPTH. No wrap-around; full is count==DEPTH.
// TESTING
//  1 reset mid-run with 3 entries -> count_o=0, out_valid_o=0, in_ready_o=1 immediately.
//  2 enqueue choose=11, all 4 data_valid=1, out_ready=0 -> next cycle count=2, out_valid=1,
//    payload=slot0; then out_ready=1 -> slot0 issues, then slot1, then count=0.
//  3 enqueue src0 preg=5 not ready; next cycle cdb0 preg=5 data=0xDEADBEEF -> out_valid=0 in
//    that cycle, then out_valid=1 with out_src0_o=0xDEADBEEF the cycle after.
//  4 enqueue with src preg=9 while cdb1 writes preg=9 data=0x1234 -> entry ready on arrival,
//    issues next cycle with src=0x1234.
//  5 older entry waiting on preg 7, younger entry ready -> younger issues first; after the
//    preg-7 wakeup the older entry issues.
//  6 fill to DEPTH-1 -> in_ready=0 even with a concurrent issue. Flush with 4 entries ->
//    out_valid=0 that cycle, count=0 next cycle, and a concurrent enqueue is dropped.

Source files
------------

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - age-ordered collapsing ALU issue queue with CDB wakeup
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush_i               drop every entry and block issue/enqueue this cycle
//   in_valid_i/in_ready_o dispatch packet handshake (ready means two free entries)
//   in_choose_i           per-slot select for the 2-slot dispatch packet
//   in_preg_i/in_data_i/in_data_valid_i  per-operand source info, index slot*2+src
//   in_payload_i          opaque per-slot control bits carried to issue
//   cdb_valid_i/cdb_preg_i/cdb_data_i    two result-broadcast ports for wakeup
//   out_valid_o/out_ready_i              issue handshake toward the ALU
//   out_src0_o/out_src1_o/out_payload_o  operands and payload of the issued entry
//   count_o               number of occupied entries
module alu_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int PREG_W    = 6,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [1:0]                 in_choose_i,
    input  logic [4*PREG_W-1:0]        in_preg_i,
    input  logic [4*DATA_W-1:0]        in_data_i,
    input  logic [3:0]                 in_data_valid_i,
    input  logic [2*PAYLOAD_W-1:0]     in_payload_i,
    input  logic [1:0]                 cdb_valid_i,
    input  logic [2*PREG_W-1:0]        cdb_preg_i,
    input  logic [2*DATA_W-1:0]        cdb_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_src0_o,
    output logic [DATA_W-1:0]          out_src1_o,
    output logic [PAYLOAD_W-1:0]       out_payload_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [CW-1:0]        count_q, count_d;
    logic [PREG_W-1:0]    preg_q    [DEPTH][2];
    logic [PREG_W-1:0]    preg_d    [DEPTH][2];
    logic [DATA_W-1:0]    data_q    [DEPTH][2];
    logic [DATA_W-1:0]    data_d    [DEPTH][2];
    logic                 rdy_q     [DEPTH][2];
    logic                 rdy_d     [DEPTH][2];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];

    // Entry operands after this cycle's CDB wakeup (before compaction).
    logic [DATA_W-1:0]    wk_data   [DEPTH][2];
    logic                 wk_rdy    [DEPTH][2];

    // Incoming operands after same-cycle CDB bypass.
    logic [DATA_W-1:0]    in_dat    [4];
    logic                 in_rdy    [4];

    logic                 sel_found;
    logic [IW-1:0]        sel_idx;
    logic                 deq;
    logic                 enq;

    logic [PREG_W-1:0]    cdb_preg0, cdb_preg1;
    logic [DATA_W-1:0]    cdb_data0, cdb_data1;

    assign cdb_preg0 = cdb_preg_i[0 +: PREG_W];
    assign cdb_preg1 = cdb_preg_i[PREG_W +: PREG_W];
    assign cdb_data0 = cdb_data_i[0 +: DATA_W];
    assign cdb_data1 = cdb_data_i[DATA_W +: DATA_W];

    // Ready reflects registered occupancy only, so dispatch never sees a
    // combinational path through the issue handshake.
    assign in_ready_o = (count_q <= CW'(DEPTH - 2)) & ~flush_i;
    assign enq        = in_valid_i & in_ready_o;

    // Oldest-ready select from registered state: a wakeup this cycle only
    // becomes visible to select after the edge.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (CW'(i) < count_q && rdy_q[i][0] && rdy_q[i][1]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign out_valid_o   = sel_found & ~flush_i;
    assign out_src0_o    = data_q[sel_idx][0];
    assign out_src1_o    = data_q[sel_idx][1];
    assign out_payload_o = payload_q[sel_idx];
    assign count_o       = count_q;
    assign deq           = out_valid_o & out_ready_i;

    // Wakeup of stored operands; port 0 has priority when both ports match.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < 2; s++) begin
                wk_rdy[i][s]  = rdy_q[i][s];
                wk_data[i][s] = data_q[i][s];
                if (CW'(i) < count_q && !rdy_q[i][s]) begin
                    if (cdb_valid_i[0] && preg_q[i][s] == cdb_preg0) begin
                        wk_rdy[i][s]  = 1'b1;
                        wk_data[i][s] = cdb_data0;
                    end else if (cdb_valid_i[1] && preg_q[i][s] == cdb_preg1) begin
                        wk_rdy[i][s]  = 1'b1;
                        wk_data[i][s] = cdb_data1;
                    end
                end
            end
        end
    end

    // Incoming operands that are not yet valid can be satisfied by a result
    // broadcast in the very same cycle they are written.
    always_comb begin
        for (int o = 0; o < 4; o++) begin
            in_rdy[o] = 1'b0;
            in_dat[o] = in_data_i[o*DATA_W +: DATA_W];
            if (in_data_valid_i[o]) begin
                in_rdy[o] = 1'b1;
            end else if (cdb_valid_i[0] && in_preg_i[o*PREG_W +: PREG_W] == cdb_preg0) begin
                in_rdy[o] = 1'b1;
                in_dat[o] = cdb_data0;
            end else if (cdb_valid_i[1] && in_preg_i[o*PREG_W +: PREG_W] == cdb_preg1) begin
                in_rdy[o] = 1'b1;
                in_dat[o] = cdb_data1;
            end
        end
    end

    // Next state: compact over the issued entry, then append chosen slots
    // starting at the post-compaction tail.
    always_comb begin
        int j;
        int pos;
        for (int i = 0; i < DEPTH; i++) begin
            j = i;
            if (deq && i < DEPTH - 1 && IW'(i) >= sel_idx) begin
                j = i + 1;
            end
            payload_d[i] = payload_q[j];
            for (int s = 0; s < 2; s++) begin
                preg_d[i][s] = preg_q[j][s];
                data_d[i][s] = wk_data[j][s];
                rdy_d[i][s]  = wk_rdy[j][s];
            end
        end

        pos = int'(count_q) - (deq ? 1 : 0);
        for (int k = 0; k < 2; k++) begin
            if (enq && in_choose_i[k] && pos < DEPTH) begin
                payload_d[pos] = in_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
                for (int s = 0; s < 2; s++) begin
                    preg_d[pos][s] = in_preg_i[(k*2+s)*PREG_W +: PREG_W];
                    data_d[pos][s] = in_dat[k*2+s];
                    rdy_d[pos][s]  = in_rdy[k*2+s];
                end
                pos = pos + 1;
            end
        end

        count_d = flush_i ? '0 : CW'(pos);
    end

    // Occupancy is the only state that needs reset: entries at or above
    // count_q are treated as invalid regardless of their contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            payload_q[i] <= payload_d[i];
            for (int s = 0; s < 2; s++) begin
                preg_q[i][s] <= preg_d[i][s];
                data_q[i][s] <= data_d[i][s];
                rdy_q[i][s]  <= rdy_d[i][s];
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - scoreboard bench for alu_issue_queue
module tb_alu_issue_queue;

    localparam int DEPTH     = 8;
    localparam int PREG_W    = 6;
    localparam int DATA_W    = 32;
    localparam int PAYLOAD_W = 64;
    localparam int CW        = $clog2(DEPTH + 1);

    logic                   clk;
    logic                   rst_n;
    logic                   flush_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [1:0]             in_choose_i;
    logic [4*PREG_W-1:0]    in_preg_i;
    logic [4*DATA_W-1:0]    in_data_i;
    logic [3:0]             in_data_valid_i;
    logic [2*PAYLOAD_W-1:0] in_payload_i;
    logic [1:0]             cdb_valid_i;
    logic [2*PREG_W-1:0]    cdb_preg_i;
    logic [2*DATA_W-1:0]    cdb_data_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [DATA_W-1:0]      out_src0_o;
    logic [DATA_W-1:0]      out_src1_o;
    logic [PAYLOAD_W-1:0]   out_payload_o;
    logic [CW-1:0]          count_o;

    alu_issue_queue #(
        .DEPTH(DEPTH), .PREG_W(PREG_W), .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_choose_i(in_choose_i),
        .in_preg_i(in_preg_i), .in_data_i(in_data_i), .in_data_valid_i(in_data_valid_i),
        .in_payload_i(in_payload_i), .cdb_valid_i(cdb_valid_i), .cdb_preg_i(cdb_preg_i),
        .cdb_data_i(cdb_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_src0_o(out_src0_o), .out_src1_o(out_src1_o), .out_payload_o(out_payload_o),
        .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0]    src0;
        logic [DATA_W-1:0]    src1;
        logic [PAYLOAD_W-1:0] payload;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] s0, input logic [31:0] s1, input logic [63:0] pl);
        exp_t e;
        e.src0 = s0; e.src1 = s1; e.payload = pl;
        sb.push_back(e);
    endtask

    // Issue monitor: every accepted issue is compared with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_issue", {32'h0, out_src0_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("issue_src0", {32'h0, out_src0_o}, {32'h0, e.src0});
                check("issue_src1", {32'h0, out_src1_o}, {32'h0, e.src1});
                check("issue_payload", out_payload_o, e.payload);
            end
        end
    end

    task automatic clr();
        in_valid_i      = 1'b0;
        in_choose_i     = 2'b00;
        in_preg_i       = '0;
        in_data_i       = '0;
        in_data_valid_i = 4'b0000;
        in_payload_i    = '0;
        cdb_valid_i     = 2'b00;
        cdb_preg_i      = '0;
        cdb_data_i      = '0;
        flush_i         = 1'b0;
    endtask

    task automatic set_slot(input int k,
                            input logic [PREG_W-1:0] p0, input logic [31:0] d0, input logic v0,
                            input logic [PREG_W-1:0] p1, input logic [31:0] d1, input logic v1,
                            input logic [63:0] pl);
        in_valid_i                        = 1'b1;
        in_choose_i[k]                    = 1'b1;
        in_preg_i[(k*2)*PREG_W +: PREG_W]   = p0;
        in_preg_i[(k*2+1)*PREG_W +: PREG_W] = p1;
        in_data_i[(k*2)*DATA_W +: DATA_W]   = d0;
        in_data_i[(k*2+1)*DATA_W +: DATA_W] = d1;
        in_data_valid_i[k*2]              = v0;
        in_data_valid_i[k*2+1]            = v1;
        in_payload_i[k*PAYLOAD_W +: PAYLOAD_W] = pl;
    endtask

    task automatic set_cdb(input int p, input logic [PREG_W-1:0] pr, input logic [31:0] d);
        cdb_valid_i[p]                = 1'b1;
        cdb_preg_i[p*PREG_W +: PREG_W] = pr;
        cdb_data_i[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        out_ready_i = 1'b0;
        clr();
        cyc(); cyc();
        rst_n = 1'b1;
        #1;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);

        // Reset mid-run with three waiting entries.
        set_slot(0, 6'd20, 32'h0, 1'b0, 6'd21, 32'h0, 1'b0, 64'hA0);
        set_slot(1, 6'd22, 32'h0, 1'b0, 6'd23, 32'h0, 1'b0, 64'hA1);
        cyc(); clr();
        set_slot(0, 6'd24, 32'h0, 1'b0, 6'd25, 32'h0, 1'b0, 64'hA2);
        cyc(); clr();
        check("midrun_count3", 64'(count_o), 64'd3);
        rst_n = 1'b0;
        #1;
        check("midrst_count", 64'(count_o), 64'd0);
        check("midrst_out_valid", 64'(out_valid_o), 64'd0);
        check("midrst_in_ready", 64'(in_ready_o), 64'd1);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Two ready slots, issue held, then released in age order.
        set_slot(0, 6'd1, 32'h1111_0000, 1'b1, 6'd2, 32'h1111_0001, 1'b1, 64'hB0);
        set_slot(1, 6'd3, 32'h2222_0000, 1'b1, 6'd4, 32'h2222_0001, 1'b1, 64'hB1);
        push(32'h1111_0000, 32'h1111_0001, 64'hB0);
        push(32'h2222_0000, 32'h2222_0001, 64'hB1);
        cyc(); clr();
        check("s2_count2", 64'(count_o), 64'd2);
        check("s2_out_valid", 64'(out_valid_o), 64'd1);
        check("s2_hold_payload", out_payload_o, 64'hB0);
        out_ready_i = 1'b1;
        cyc();
        check("s2_count1", 64'(count_o), 64'd1);
        cyc();
        check("s2_count0", 64'(count_o), 64'd0);

        // Enqueue with choose=00 writes nothing.
        in_valid_i = 1'b1;
        cyc(); clr();
        check("choose00_count", 64'(count_o), 64'd0);

        // Wakeup in cycle N, issue in cycle N+1.
        set_slot(0, 6'd5, 32'h0, 1'b0, 6'd6, 32'h0000_0011, 1'b1, 64'hC0);
        cyc(); clr();
        check("s3_count1", 64'(count_o), 64'd1);
        set_cdb(0, 6'd5, 32'hDEAD_BEEF);
        #1;
        check("s3_no_same_cycle_issue", 64'(out_valid_o), 64'd0);
        push(32'hDEAD_BEEF, 32'h0000_0011, 64'hC0);
        cyc(); clr();
        check("s3_out_valid", 64'(out_valid_o), 64'd1);
        check("s3_src0", 64'(out_src0_o), 64'hDEAD_BEEF);
        cyc();
        check("s3_count0", 64'(count_o), 64'd0);

        // Enqueue bypass from CDB port 1, slot 1 only.
        set_slot(1, 6'd9, 32'h0, 1'b0, 6'd10, 32'h0000_0055, 1'b1, 64'hD1);
        set_cdb(1, 6'd9, 32'h0000_1234);
        push(32'h0000_1234, 32'h0000_0055, 64'hD1);
        cyc(); clr();
        check("s4_out_valid", 64'(out_valid_o), 64'd1);
        check("s4_src0", 64'(out_src0_o), 64'h1234);
        cyc();
        check("s4_count0", 64'(count_o), 64'd0);

        // Younger ready entry bypasses an older waiting one; port 0 priority.
        set_slot(0, 6'd7, 32'h0, 1'b0, 6'd8, 32'h0000_0088, 1'b1, 64'hE0);
        set_slot(1, 6'd11, 32'h0000_0B0B, 1'b1, 6'd12, 32'h0000_0C0C, 1'b1, 64'hE1);
        push(32'h0000_0B0B, 32'h0000_0C0C, 64'hE1);
        cyc(); clr();
        check("s5_young_first", out_payload_o, 64'hE1);
        cyc();
        check("s5_count1", 64'(count_o), 64'd1);
        check("s5_old_waiting", 64'(out_valid_o), 64'd0);
        set_cdb(0, 6'd7, 32'h0000_0077);
        set_cdb(1, 6'd7, 32'h0000_0099);
        push(32'h0000_0077, 32'h0000_0088, 64'hE0);
        cyc(); clr();
        check("s5_old_issue", out_payload_o, 64'hE0);
        cyc();
        check("s5_count0", 64'(count_o), 64'd0);

        // Fill to DEPTH-1, then flush with four entries.
        out_ready_i = 1'b0;
        for (int n = 0; n < 3; n++) begin
            set_slot(0, 6'd1, 32'(n*16), 1'b1, 6'd2, 32'(n*16+1), 1'b1, 64'(16'hF000 + n*2));
            set_slot(1, 6'd3, 32'(n*16+2), 1'b1, 6'd4, 32'(n*16+3), 1'b1, 64'(16'hF001 + n*2));
            push(32'(n*16), 32'(n*16+1), 64'(16'hF000 + n*2));
            push(32'(n*16+2), 32'(n*16+3), 64'(16'hF001 + n*2));
            cyc(); clr();
        end
        check("s6_count6", 64'(count_o), 64'd6);
        check("s6_ready_at6", 64'(in_ready_o), 64'd1);
        set_slot(0, 6'd1, 32'h0000_0700, 1'b1, 6'd2, 32'h0000_0701, 1'b1, 64'hF0F0);
        push(32'h0000_0700, 32'h0000_0701, 64'hF0F0);
        cyc(); clr();
        check("s6_count7", 64'(count_o), 64'd7);
        check("s6_not_ready_at7", 64'(in_ready_o), 64'd0);
        out_ready_i = 1'b1;
        #1;
        check("s6_not_ready_with_issue", 64'(in_ready_o), 64'd0);
        cyc(); cyc(); cyc();
        check("s6_count4", 64'(count_o), 64'd4);
        out_ready_i = 1'b0;
        flush_i     = 1'b1;
        set_slot(0, 6'd1, 32'h1, 1'b1, 6'd2, 32'h2, 1'b1, 64'hDEAD);
        set_slot(1, 6'd3, 32'h3, 1'b1, 6'd4, 32'h4, 1'b1, 64'hBEEF);
        #1;
        check("flush_out_valid", 64'(out_valid_o), 64'd0);
        check("flush_in_ready", 64'(in_ready_o), 64'd0);
        sb.delete();
        cyc(); clr();
        check("flush_count0", 64'(count_o), 64'd0);
        check("flush_out_valid_after", 64'(out_valid_o), 64'd0);
        cyc();
        check("flush_enq_dropped", 64'(count_o), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
